fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl.sv | 137 +++++++++++++
 tb/tb_fifo_read_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer, read pointer, status flags.
// Optional build macro FIFO_RD_UNDERFLOW_STICKY_EN makes underflow sticky until reset.
module fifo_read_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          rclk,
  input  logic          hw_rst,
  input  logic          sw_rst,
  input  logic          read_enable,
  input  logic [AW-1:0] aempty_value,
  input  logic [AW:0]   wptr_gray,
  output logic [AW-1:0] raddr,
  output logic          mem_rd_en,
  output logic [AW:0]   rptr_gray,
  output logic          rempty,
  output logic          rd_almost_empty,
  output logic          underflow,
  output logic [AW:0]   fifo_read_count,
  output logic [AW:0]   rd_level
);

  typedef enum logic [0:0] {EMPTY = 1'b0, AVAIL = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t      state_r, state_s;
  logic [AW:0] wq1_r, wq2_r, rbin_r, rptr_gray_r, count_r, level_r;
  logic        ae_r, uf_r;
  logic        accept_s, uf_set_s;
  logic [AW:0] rbin_next_s, count_next_s;

  // Two-flop synchronizer for the write-domain Gray pointer
  always_ff @(posedge rclk or posedge hw_rst) begin
    if (hw_rst) begin
      wq1_r <= {(AW+1){1'b0}};
      wq2_r <= {(AW+1){1'b0}};
    end else if (sw_rst) begin
      wq1_r <= {(AW+1){1'b0}};
      wq2_r <= {(AW+1){1'b0}};
    end else begin
      wq1_r <= wptr_gray;
      wq2_r <= wq1_r;
    end
  end

  // Next pointer and occupancy; everything downstream compares against wq2 only
  always_comb begin
    accept_s     = read_enable & (state_r == AVAIL);
    uf_set_s     = read_enable & (state_r == EMPTY);
    rbin_next_s  = rbin_r + {{AW{1'b0}}, accept_s};
    count_next_s = gray2bin(wq2_r) - rbin_next_s;
  end

  // State register
  always_ff @(posedge rclk or posedge hw_rst) begin
    if (hw_rst) begin
      state_r <= EMPTY;
    end else if (sw_rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: empty whenever the next read pointer meets the synchronized write pointer
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (bin2gray(rbin_next_s) != wq2_r) state_s = AVAIL;
        else                                state_s = EMPTY;
      end
      AVAIL: begin
        if (bin2gray(rbin_next_s) == wq2_r) state_s = EMPTY;
        else                                state_s = AVAIL;
      end
      default: state_s = EMPTY;
    endcase
  end

  // Pointer and status registers
  always_ff @(posedge rclk or posedge hw_rst) begin
    if (hw_rst) begin
      rbin_r      <= {(AW+1){1'b0}};
      rptr_gray_r <= {(AW+1){1'b0}};
      count_r     <= {(AW+1){1'b0}};
      level_r     <= DEPTH_V;
      ae_r        <= 1'b1;
      uf_r        <= 1'b0;
    end else if (sw_rst) begin
      rbin_r      <= {(AW+1){1'b0}};
      rptr_gray_r <= {(AW+1){1'b0}};
      count_r     <= {(AW+1){1'b0}};
      level_r     <= DEPTH_V;
      ae_r        <= 1'b1;
      uf_r        <= 1'b0;
    end else begin
      rbin_r      <= rbin_next_s;
      rptr_gray_r <= bin2gray(rbin_next_s);
      count_r     <= count_next_s;
      level_r     <= DEPTH_V - count_next_s;
      ae_r        <= (count_next_s <= {1'b0, aempty_value});
`ifdef FIFO_RD_UNDERFLOW_STICKY_EN
      uf_r        <= uf_r | uf_set_s;
`else
      uf_r        <= uf_set_s;
`endif
    end
  end

  // Output decode
  always_comb begin
    mem_rd_en       = accept_s;
    raddr           = rbin_r[AW-1:0];
    rempty          = (state_r == EMPTY);
    rptr_gray       = rptr_gray_r;
    fifo_read_count = count_r;
    rd_level        = level_r;
    rd_almost_empty = ae_r;
    underflow       = uf_r;
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios plus random traffic against an occupancy model.
module tb_fifo_read_ctrl;
  logic       rclk = 1'b0;
  logic       hw_rst = 1'b1, sw_rst = 1'b0, read_enable = 1'b0;
  logic [4:0] aempty_value = 5'd4;
  logic [5:0] wptr_gray = 6'd0;
  logic [4:0] raddr;
  logic       mem_rd_en, rempty, rd_almost_empty, underflow;
  logic [5:0] rptr_gray, fifo_read_count, rd_level;

  fifo_read_ctrl #(.DEPTH(32), .AW(5)) dut (
    .rclk(rclk), .hw_rst(hw_rst), .sw_rst(sw_rst), .read_enable(read_enable),
    .aempty_value(aempty_value), .wptr_gray(wptr_gray), .raddr(raddr),
    .mem_rd_en(mem_rd_en), .rptr_gray(rptr_gray), .rempty(rempty),
    .rd_almost_empty(rd_almost_empty), .underflow(underflow),
    .fifo_read_count(fifo_read_count), .rd_level(rd_level)
  );

  always #5 rclk = ~rclk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: binary write count (what the writer has produced), its two-cycle delayed view, reads done
  logic [5:0] wbin, m_s1, m_s2, m_rd, m_cnt;
  bit         m_empty, m_ae, m_uf;

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 6'd0; m_s2 = 6'd0; m_rd = 6'd0; m_cnt = 6'd0;
    m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
  endtask

  task automatic model_edge();
    bit take;
    bit uf_now;
    if (sw_rst) begin
      model_reset();
    end else begin
      take   = read_enable && !m_empty;
      uf_now = read_enable && m_empty;
      m_rd   = m_rd + {5'd0, take};
      m_cnt  = m_s2 - m_rd;
      m_empty = (m_cnt == 6'd0);
      m_ae    = (m_cnt <= {1'b0, aempty_value});
`ifdef FIFO_RD_UNDERFLOW_STICKY_EN
      m_uf = m_uf || uf_now;
`else
      m_uf = uf_now;
`endif
      m_s2 = m_s1;
      m_s1 = wbin;
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".rempty"}, rempty, m_empty);
    check_eq({tag, ".count"}, fifo_read_count, m_cnt);
    check_eq({tag, ".level"}, rd_level, 32 - m_cnt);
    check_eq({tag, ".aempty"}, rd_almost_empty, m_ae);
    check_eq({tag, ".underflow"}, underflow, m_uf);
    check_eq({tag, ".rptr_gray"}, rptr_gray, to_gray(m_rd));
  endtask

  // One clock: drive at negedge, check strobes, advance model on posedge, check registers at next negedge
  task automatic cycle(input bit re, input string tag);
    read_enable = re;
    wptr_gray   = to_gray(wbin);
    #1;
    check_eq({tag, ".mem_rd_en"}, mem_rd_en, re && !m_empty);
    if (re && !m_empty) check_eq({tag, ".raddr"}, raddr, m_rd[4:0]);
    @(posedge rclk);
    model_edge();
    @(negedge rclk);
    check_regs(tag);
  endtask

  task automatic hard_reset();
    hw_rst = 1'b1; read_enable = 1'b0; wbin = 6'd0; wptr_gray = 6'd0;
    #1;
    model_reset();
    check_regs("hw_rst");
    check_eq("hw_rst.level32", rd_level, 32);
    @(negedge rclk);
    hw_rst = 1'b0;
  endtask

  task automatic soft_reset();
    sw_rst = 1'b1; wbin = 6'd0;
    cycle(1'b1, "sw_rst");
    check_eq("sw_rst.rptr0", rptr_gray, 0);
    sw_rst = 1'b0;
  endtask

  initial begin
    wbin = 6'd0;
    model_reset();
    @(negedge rclk);
    hard_reset();

    // Synchronizer latency: visible after the third edge, not before
    wbin = 6'd1;
    cycle(1'b0, "sync1"); check_eq("sync1.still_empty", rempty, 1);
    cycle(1'b0, "sync2"); check_eq("sync2.still_empty", rempty, 1);
    cycle(1'b0, "sync3");
    check_eq("sync3.rempty", rempty, 0);
    check_eq("sync3.count", fifo_read_count, 1);
    check_eq("sync3.level", rd_level, 31);

    // Full drain of 32 entries
    hard_reset();
    wbin = 6'd32;
    repeat (3) cycle(1'b0, "fill");
    check_eq("fill.count32", fifo_read_count, 32);
    for (int i = 0; i < 32; i++) begin
      read_enable = 1'b1;
      #1;
      check_eq("drain.raddr", raddr, i);
      check_eq("drain.en", mem_rd_en, 1);
      cycle(1'b1, "drain");
    end
    check_eq("drain.rempty", rempty, 1);
    check_eq("drain.rptr", rptr_gray, 6'd48);

    // Wrap: bring pointer to 63 with one entry left, then read it
    wbin = 6'd63;
    repeat (3) cycle(1'b0, "wfill");
    repeat (31) cycle(1'b1, "wread");
    wbin = 6'd0;
    repeat (3) cycle(1'b0, "wsync");
    check_eq("wrap.count1", fifo_read_count, 1);
    cycle(1'b1, "wrap");
    check_eq("wrap.rptr0", rptr_gray, 0);
    check_eq("wrap.rempty", rempty, 1);

    // Almost-empty threshold at 4 with 6 entries
    hard_reset();
    aempty_value = 5'd4;
    wbin = 6'd6;
    repeat (3) cycle(1'b0, "ae_fill");
    check_eq("ae.at6", rd_almost_empty, 0);
    cycle(1'b1, "ae_r1"); check_eq("ae.at5", rd_almost_empty, 0);
    cycle(1'b1, "ae_r2"); check_eq("ae.at4", rd_almost_empty, 1);

    // Underflow: three rejected reads while empty
    hard_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, "uf");
      check_eq("uf.set", underflow, 1);
      check_eq("uf.rptr", rptr_gray, 0);
    end
    cycle(1'b0, "uf_idle");
`ifdef FIFO_RD_UNDERFLOW_STICKY_EN
    check_eq("uf.sticky", underflow, 1);
`else
    check_eq("uf.pulse", underflow, 0);
`endif
    soft_reset();
    check_eq("uf.cleared", underflow, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        soft_reset();
      end else begin
        if ($urandom_range(0, 31) == 0) aempty_value = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1 && (wbin - m_rd) < 6'd32) wbin = wbin + 6'd1;
        cycle(1'($urandom_range(0, 1)), "rand");
      end
    end

    // Reset mid-operation with a read pending
    wbin = wbin + 6'd1;
    read_enable = 1'b1;
    hard_reset();
    cycle(1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
